// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle used by both requester ports and the memory port.
// Latency: plain wires, no registers.
// Backpressure: requests are level-held until ack; the responder stalls by delaying ack.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              re;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        len;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   // Request issuer: drives the command, receives data and completion.
   modport master (
      output re, we, addr, len, wdata,
      input  rdata, ack
   );

   // Request server: receives the command, returns data and completion.
   modport slave (
      input  re, we, addr, len, wdata,
      output rdata, ack
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (p0, read-only) and data access (p1, read/write); ARB_RR_EN selects round-robin.
// Latency: strobe one cycle after the request is seen; port ack one cycle after m_ack; next grant two cycles after that.
// Backpressure: requests are level-held until their ack; memory stalls the owner simply by withholding m_ack.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave  p0,
   mem_port_arbiter_if.slave  p1,
   mem_port_arbiter_if.master m
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   // Registered memory-side command.
   logic              m_re;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [1:0]        m_len;
   logic [DATA_W-1:0] m_wdata;

   // Registered requester-side responses.
   logic [DATA_W-1:0] p0_rdata;
   logic              p0_ack;
   logic [DATA_W-1:0] p1_rdata;
   logic              p1_ack;

   // Request decode. Port 1 with both re and we high is treated as a write.
   logic p0_pend;
   logic p1_pend;
   logic p1_wr;

   assign p0_pend = p0.re;
   assign p1_pend = p1.re | p1.we;
   assign p1_wr   = p1.we;

   // Fetch port is read-only; its write-side fields carry nothing.
   logic unused_p0;
   assign unused_p0 = ^{p0.we, p0.wdata};

   // One-cycle decisions produced by the FSM.
   logic grant0;
   logic grant1;
   logic mem_done;

   // Tie-break: does port 1 win when it is pending in IDLE?
   logic p1_wins;

`ifdef ARB_RR_EN
   // Port granted most recently: 0 = fetch, 1 = data.
   logic last_grant;

   assign p1_wins = !p0_pend || !last_grant;
`else
   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   // Consecutive data grants taken while fetch was waiting.
   logic [2:0] starve_cnt;

   assign p1_wins = !(p0_pend && (starve_cnt == STARVE_LIM));
`endif

   // State register; an asynchronous reset abandons any open transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and grant/completion decisions; m_ack outside BUSY0/BUSY1 is ignored.
   always_comb begin
      state_nxt = state;
      grant0    = 1'b0;
      grant1    = 1'b0;
      mem_done  = 1'b0;
      case (state)
         IDLE: begin
            if (p1_pend && p1_wins) begin
               grant1    = 1'b1;
               state_nxt = BUSY1;
            end else if (p0_pend) begin
               grant0    = 1'b1;
               state_nxt = BUSY0;
            end
         end
         BUSY0, BUSY1: begin
            if (m.ack) begin
               mem_done  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            // The ack cycle: requesters drop their request here, so no grant yet.
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Memory command: latch the winner on grant, hold it stable, drop the strobe on completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_re    <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_len   <= 2'd0;
         m_wdata <= '0;
      end else if (grant0) begin
         m_re    <= 1'b1;
         m_we    <= 1'b0;
         m_addr  <= p0.addr;
         m_len   <= p0.len;
         m_wdata <= '0;
      end else if (grant1) begin
         m_re    <= !p1_wr;
         m_we    <= p1_wr;
         m_addr  <= p1.addr;
         m_len   <= p1.len;
         m_wdata <= p1.wdata;
      end else if (mem_done) begin
         m_re    <= 1'b0;
         m_we    <= 1'b0;
      end
   end

   // Completion: one-cycle ack to the owner, read data captured; stores leave p1_rdata alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p0_ack   <= 1'b0;
         p1_ack   <= 1'b0;
         p0_rdata <= '0;
         p1_rdata <= '0;
      end else begin
         p0_ack <= 1'b0;
         p1_ack <= 1'b0;
         if (mem_done) begin
            if (state == BUSY0) begin
               p0_ack   <= 1'b1;
               p0_rdata <= m.rdata;
            end else begin
               p1_ack <= 1'b1;
               if (!m_we) begin
                  p1_rdata <= m.rdata;
               end
            end
         end
      end
   end

`ifdef ARB_RR_EN
   // Remember who won last so the other port takes the next tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b0;
      end else if (grant0) begin
         last_grant <= 1'b0;
      end else if (grant1) begin
         last_grant <= 1'b1;
      end
   end
`else
   // Starvation guard: count data grants that bypassed a waiting fetch, saturating at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= 3'd0;
      end else if (grant0) begin
         starve_cnt <= 3'd0;
      end else if (grant1) begin
         if (!p0_pend) begin
            starve_cnt <= 3'd0;
         end else if (starve_cnt < STARVE_LIM) begin
            starve_cnt <= starve_cnt + 3'd1;
         end
      end
   end
`endif

   assign m.re     = m_re;
   assign m.we     = m_we;
   assign m.addr   = m_addr;
   assign m.len    = m_len;
   assign m.wdata  = m_wdata;

   assign p0.rdata = p0_rdata;
   assign p0.ack   = p0_ack;
   assign p1.rdata = p1_rdata;
   assign p1.ack   = p1_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p0_bus ();
   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p1_bus ();
   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_bus ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .p0  (p0_bus),
      .p1  (p1_bus),
      .m   (m_bus)
   );

   int checks = 0;
   int errors = 0;

   // Transaction-level reference model.
   int                cyc       = 0;
   bit                own_vld   = 1'b0;
   int                owner     = 0;
   int                grant_cyc = 0;
   int                lat       = 1;
   int                free_edge = 0;
   int                ngrant    = 0;
   logic [ADDR_W-1:0] exp_addr  = '0;
   logic [1:0]        exp_len   = 2'd0;
   logic [DATA_W-1:0] exp_wdata = '0;
   bit                exp_we    = 1'b0;
   logic [DATA_W-1:0] exp_rd0   = '0;
   logic [DATA_W-1:0] exp_rd1   = '0;
   logic [DATA_W-1:0] mem_data  = '0;
`ifdef ARB_RR_EN
   int last_g = 0;
`else
   int starve = 0;
`endif

   // Observations of the DUT.
   int acks[$];
   int ack0_cyc = -1, ack1_cyc = -1, mack_cyc = -1, p1_mack_cyc = -1, rise_cyc = -1;
   int n_re = 0, n_we = 0;
   bit prev_strobe = 1'b0;

   // Stimulus knobs.
   bit auto0 = 0, auto1 = 0, auto1_wr = 0, rand_req = 0, stray_all = 0, stray_rand = 0;
   int fixed_lat = 0;
   bit use_fix = 0;
   logic [DATA_W-1:0] fix_data = '0;
   int exp_seq [10];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic new_p0();
      p0_bus.re   = 1'b1;
      p0_bus.addr = $urandom;
      case ($urandom_range(0, 2))
         0:       p0_bus.len = 2'd0;
         1:       p0_bus.len = 2'd1;
         default: p0_bus.len = 2'd3;
      endcase
   endtask

   task automatic new_p1();
      int kind;
      kind = auto1_wr ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2);
      p1_bus.re    = (kind != 1);
      p1_bus.we    = (kind != 0);
      p1_bus.addr  = $urandom;
      p1_bus.wdata = $urandom;
      case ($urandom_range(0, 2))
         0:       p1_bus.len = 2'd0;
         1:       p1_bus.len = 2'd1;
         default: p1_bus.len = 2'd3;
      endcase
   endtask

   // Winner of an IDLE decision from the pending set, by the arbitration rules.
   function automatic int arbitrate(input bit r0, input bit r1);
`ifdef ARB_RR_EN
      if (r0 && r1) return (last_g == 0) ? 1 : 0;
      return r1 ? 1 : 0;
`else
      if (r1 && !(r0 && starve == STARVE_MAX)) return 1;
      return 0;
`endif
   endfunction

   // One clock: predict the edge's effect, check, then drive the next cycle's inputs.
   task automatic step();
      bit pend0, pend1, ackd, exp_a0, exp_a1;
      int win;
      pend0 = p0_bus.re;
      pend1 = p1_bus.re | p1_bus.we;
      ackd  = m_bus.ack;
      @(posedge clk); #1;
      cyc++;
      exp_a0 = 1'b0;
      exp_a1 = 1'b0;
      if (own_vld && ackd) begin
         own_vld   = 1'b0;
         free_edge = cyc + 2;
         if (owner == 0) begin
            exp_a0  = 1'b1;
            exp_rd0 = mem_data;
         end else begin
            exp_a1 = 1'b1;
            if (!exp_we) exp_rd1 = mem_data;
         end
      end else if (!own_vld && cyc >= free_edge && (pend0 || pend1)) begin
         win = arbitrate(pend0, pend1);
`ifdef ARB_RR_EN
         last_g = win;
`else
         if (win == 1) starve = pend0 ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
         else          starve = 0;
`endif
         own_vld   = 1'b1;
         owner     = win;
         grant_cyc = cyc;
         ngrant++;
         lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 3);
         if (win == 0) begin
            exp_we = 1'b0; exp_addr = p0_bus.addr; exp_len = p0_bus.len; exp_wdata = '0;
         end else begin
            exp_we = p1_bus.we; exp_addr = p1_bus.addr; exp_len = p1_bus.len; exp_wdata = p1_bus.wdata;
         end
      end

      if (own_vld) begin
         chk("m_re", m_bus.re, !exp_we);
         chk("m_we", m_bus.we, exp_we);
         chk("m_addr", m_bus.addr, exp_addr);
         chk("m_len", m_bus.len, exp_len);
         if (exp_we) chk("m_wdata", m_bus.wdata, exp_wdata);
      end else begin
         chk("m_re_idle", m_bus.re, 1'b0);
         chk("m_we_idle", m_bus.we, 1'b0);
      end
      chk("p0_ack", p0_bus.ack, exp_a0);
      chk("p1_ack", p1_bus.ack, exp_a1);
      chk("p0_rdata", p0_bus.rdata, exp_rd0);
      chk("p1_rdata", p1_bus.rdata, exp_rd1);

      n_re += int'(m_bus.re);
      n_we += int'(m_bus.we);
      if ((m_bus.re || m_bus.we) && !prev_strobe) rise_cyc = cyc;
      prev_strobe = m_bus.re | m_bus.we;
      if (p0_bus.ack) begin acks.push_back(0); ack0_cyc = cyc; end
      if (p1_bus.ack) begin acks.push_back(1); ack1_cyc = cyc; end

      // Requesters: release on completion, optionally re-request at once.
      if (exp_a0) begin
         if (auto0 || (rand_req && $urandom_range(0, 1) == 0)) new_p0();
         else p0_bus.re = 1'b0;
      end else if (!p0_bus.re && rand_req && $urandom_range(0, 3) == 0) begin
         new_p0();
      end
      if (exp_a1) begin
         p1_mack_cyc = mack_cyc;
         if (auto1 || (rand_req && $urandom_range(0, 1) == 0)) new_p1();
         else begin p1_bus.re = 1'b0; p1_bus.we = 1'b0; end
      end else if (!(p1_bus.re || p1_bus.we) && rand_req && $urandom_range(0, 3) == 0) begin
         new_p1();
      end

      // Memory responder, plus stray acks while nothing is outstanding.
      m_bus.ack = 1'b0;
      if (own_vld && (cyc - grant_cyc + 1) == lat) begin
         mem_data    = use_fix ? fix_data : DATA_W'($urandom);
         m_bus.ack   = 1'b1;
         m_bus.rdata = mem_data;
         mack_cyc    = cyc;
      end else if (!own_vld && (stray_all || (stray_rand && $urandom_range(0, 3) == 0))) begin
         m_bus.ack   = 1'b1;
         m_bus.rdata = $urandom;
      end
   endtask

   task automatic check_all_zero(input string pfx);
      chk({pfx, "_m_re"}, m_bus.re, 1'b0);
      chk({pfx, "_m_we"}, m_bus.we, 1'b0);
      chk({pfx, "_m_addr"}, m_bus.addr, '0);
      chk({pfx, "_m_len"}, m_bus.len, 2'd0);
      chk({pfx, "_m_wdata"}, m_bus.wdata, '0);
      chk({pfx, "_p0_ack"}, p0_bus.ack, 1'b0);
      chk({pfx, "_p1_ack"}, p1_bus.ack, 1'b0);
      chk({pfx, "_p0_rdata"}, p0_bus.rdata, '0);
      chk({pfx, "_p1_rdata"}, p1_bus.rdata, '0);
   endtask

   // Asynchronous reset in the middle of a cycle, with a late m_ack left hanging.
   task automatic reset_now();
      #2 rst = 1'b1;
      #1 check_all_zero("rst_async");
      own_vld = 1'b0; exp_rd0 = '0; exp_rd1 = '0; prev_strobe = 1'b0;
`ifdef ARB_RR_EN
      last_g = 0;
`else
      starve = 0;
`endif
      auto0 = 0; auto1 = 0;
      p0_bus.re = 1'b0; p1_bus.re = 1'b0; p1_bus.we = 1'b0;
      m_bus.ack = 1'b1;
      @(posedge clk); #1;
      cyc++;
      rst = 1'b0;
      free_edge = cyc + 1;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (p0_bus.re || p1_bus.re || p1_bus.we || own_vld); i++) step();
      chk("drain_idle", {p0_bus.re, p1_bus.re, p1_bus.we, own_vld}, 4'd0);
   endtask

   initial begin
      p0_bus.re = 0; p0_bus.we = 0; p0_bus.addr = '0; p0_bus.len = 0; p0_bus.wdata = '0;
      p1_bus.re = 0; p1_bus.we = 0; p1_bus.addr = '0; p1_bus.len = 0; p1_bus.wdata = '0;
      m_bus.ack = 0; m_bus.rdata = '0;
`ifdef ARB_RR_EN
      exp_seq = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
      exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif

      // Reset state.
      repeat (2) @(posedge clk);
      #1 check_all_zero("reset");
      rst = 1'b0;
      free_edge = cyc + 1;

      // Single fetch, memory acks after two strobe cycles.
      fixed_lat = 2; use_fix = 1; fix_data = 32'hDEADBEEF;
      p0_bus.re = 1'b1; p0_bus.addr = 32'h100; p0_bus.len = 2'd3;
      n_re = 0; n_we = 0; ack0_cyc = -1;
      for (int i = 0; i < 20 && ack0_cyc < 0; i++) step();
      chk("fetch_done", ack0_cyc >= 0, 1'b1);
      chk("fetch_re_cycles", n_re, 2);
      chk("fetch_we_cycles", n_we, 0);
      chk("fetch_rdata", p0_bus.rdata, 32'hDEADBEEF);

      // Store: p1_rdata must be untouched.
      use_fix = 0; fixed_lat = 3;
      p1_bus.re = 1'b0; p1_bus.we = 1'b1; p1_bus.addr = 32'h2004; p1_bus.len = 2'd1; p1_bus.wdata = 32'h1234;
      n_re = 0; n_we = 0; ack1_cyc = -1;
      for (int i = 0; i < 30 && ack1_cyc < 0; i++) step();
      chk("store_done", ack1_cyc >= 0, 1'b1);
      chk("store_we_cycles", n_we, 3);
      chk("store_re_cycles", n_re, 0);
      chk("store_rdata_kept", p1_bus.rdata, 32'h0);

      // Build up starvation with data writes, then reset while port 1 owns memory.
      fixed_lat = 3; auto0 = 1; auto1 = 1; auto1_wr = 1;
      new_p0(); new_p1();
      ngrant = 0;
      for (int i = 0; i < 80 && !(ngrant >= 3 && own_vld && owner == 1); i++) step();
      chk("pre_rst_busy1_we", m_bus.we, 1'b1);
      reset_now();
      step();
      chk("late_ack_no_p1_ack", p1_bus.ack, 1'b0);
      chk("late_ack_no_strobe", m_bus.re | m_bus.we, 1'b0);

      // Continuous contention from reset, single-cycle memory.
      fixed_lat = 1; auto0 = 1; auto1 = 1; auto1_wr = 0;
      acks.delete();
      new_p0(); new_p1();
      for (int i = 0; i < 200 && acks.size() < 10; i++) step();
      chk("cont_count", acks.size() >= 10, 1'b1);
      for (int i = 0; i < 10; i++) begin
         if (i < acks.size()) chk($sformatf("cont_grant%0d", i), acks[i], exp_seq[i]);
      end
      auto0 = 0; auto1 = 0;
      drain();

      // Back-to-back spacing with stray m_ack pulses in DONE/IDLE.
      fixed_lat = 2; stray_all = 1;
      p1_bus.re = 1'b1; p1_bus.we = 1'b0; p1_bus.addr = $urandom; p1_bus.len = 2'd3;
      for (int i = 0; i < 10 && !own_vld; i++) step();
      new_p0();
      ack0_cyc = -1; ack1_cyc = -1;
      for (int i = 0; i < 30 && ack0_cyc < 0; i++) step();
      chk("space_p1_ack", ack1_cyc - p1_mack_cyc, 1);
      chk("space_next_grant", rise_cyc - p1_mack_cyc, 3);
      chk("space_p0_done", ack0_cyc >= 0, 1'b1);
      stray_all = 0;
      drain();

      // Randomised traffic against the model.
      rand_req = 1; stray_rand = 1; fixed_lat = 0;
      new_p0(); new_p1();
      repeat (500) step();
      rand_req = 0; stray_rand = 0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
